record_engine: RTL and testbench
================================

// Module: record_engine
// PURPOSE
//  Responder side of the control-core record handshake (start/select/pause/stop -> done).
//  Captures codec samples into a small FIFO. Writes them into the SDRAM chunk selected
//  by the control core, at consecutive word addresses. Reports done and the recorded length.
//  Sits between the codec receiver, the control core and the SDRAM arbiter write port.
// PARAMETERS
//  CHUNK_WORDS  23'h100000  max 16-bit words per chunk; recording auto-ends at this count
//  FIFO_DEPTH   16          sample FIFO entries; power of 2, >=4
// PORTS
//  i_clk          in   1   clock
//  i_rst          in   1   async active-high reset
//  i_start        in   1   level; held high by the control core for the whole REC session
//  i_select       in   23  chunk base word address; sampled on the i_start rising edge only
//  i_pause        in   1   level; while high, incoming samples are discarded
//  i_stop         in   1   request end of recording
//  o_done         out  1   high in DONE until i_start falls
//  i_smp_valid    in   1   one-cycle strobe: new codec sample
//  i_smp_data     in   16  codec sample
//  o_mem_write    out  1   write request
//  o_mem_addr     out  23  word address
//  o_mem_wdata    out  16  write data
//  i_mem_wait     in   1   waitrequest; a write completes on a cycle with o_mem_write & !i_mem_wait
//  o_rec_len      out  23  words written this session; valid in DONE
//  o_overflow     out  1   sticky: a sample was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; FIFO empty; counters 0.
//  States:
//   IDLE  -> REC on an i_start rising edge (start & !start_q). Latches base=i_select.
//            Clears the FIFO, acc_cnt, wr_cnt and o_overflow.
//   REC   -> accept rule: i_smp_valid & !i_pause & !i_stop & acc_cnt<CHUNK_WORDS.
//            An accepted sample is pushed if the FIFO is not full, and acc_cnt++.
//            If the FIFO is full, the sample is dropped, o_overflow<=1, and acc_cnt is unchanged.
//            -> DRAIN when i_stop=1 (priority: a same-cycle sample is not accepted).
//            -> DRAIN when acc_cnt reaches CHUNK_WORDS.
//   DRAIN -> no new samples; the FIFO keeps draining to memory.
//            -> DONE when the FIFO is empty and no write is outstanding.
//   DONE  -> o_done=1; o_rec_len=wr_cnt.
//            -> IDLE when i_start=0, the cycle after it is seen low.
//  Abort: i_start low in REC or DRAIN -> stop accepting; any in-flight write is held until
//   accepted; then flush the FIFO and go to IDLE without asserting o_done.
//  Memory port (REC and DRAIN):
//   - o_mem_write asserts when the FIFO is non-empty.
//   - addr/wdata/write stay stable while i_mem_wait=1.
//   - On completion: pop the FIFO, wr_cnt++.
//   - o_mem_addr = base + wr_cnt, modulo 2^23 (wraps silently).
//  Latency: a sample accepted in cycle N appears on o_mem_write/o_mem_wdata no earlier
//   than N+1 and no later than N+2 when the FIFO was empty and i_mem_wait=0.
//  FIFO: same-cycle push and pop are allowed at any fill level. Push is not allowed when
//   full unless a pop happens in the same cycle.
//  i_pause: no effect on draining or on i_stop handling.
//  i_stop, i_pause and i_select are ignored in IDLE and DONE.
//  Reset asserted mid-operation: immediate return to reset values; the SDRAM write is
//   abandoned.
// TESTING
//  1 base=23'h040000; start; 8 samples 16'h0001..0008 with wait=0; stop
//    -> writes to addr 040000..040007 carrying 0001..0008, in order;
//       o_done=1, o_rec_len=8; start low -> o_done=0 the next cycle.
//  2 CHUNK_WORDS=4; 6 samples; no stop -> exactly 4 writes; DONE; o_rec_len=4.
//  3 i_mem_wait=1 for 40 cycles; sample every cycle with FIFO_DEPTH=16
//    -> 16 stored; 17th dropped; o_overflow=1; addr/data held stable during the wait.
//  4 stop and i_smp_valid in the same cycle -> that sample is not written;
//    the FIFO drains; o_rec_len excludes it.
//  5 pause high for samples 3-5 of 8 -> 5 writes, contiguous addresses, samples 3-5 absent.
//  6 base=23'h7FFFFE; 4 samples -> addrs 7FFFFE, 7FFFFF, 000000, 000001.
//    Also: start dropped mid-REC with wait=1 -> the write is held until wait=0,
//    then IDLE with o_done never asserted.

Source files
------------

// File: rtl/record_engine.sv
// Record engine: buffers codec samples in a small FIFO and streams them to consecutive
// SDRAM word addresses of the chunk chosen by the control core, then reports the length.
module record_engine #(
    parameter logic [22:0] CHUNK_WORDS = 23'h100000,
    parameter int          FIFO_DEPTH  = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [22:0] i_select,
    input  logic        i_pause,
    input  logic        i_stop,
    output logic        o_done,
    input  logic        i_smp_valid,
    input  logic [15:0] i_smp_data,
    output logic        o_mem_write,
    output logic [22:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    input  logic        i_mem_wait,
    output logic [22:0] o_rec_len,
    output logic        o_overflow
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_REC,
        S_DRAIN,
        S_DONE,
        S_ABORT
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_start_q;
    logic [22:0] r_base;
    logic [22:0] r_acc_cnt;
    logic [22:0] r_wr_cnt;
    logic        r_overflow;
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [15:0] r_fifo [FIFO_DEPTH];

    logic w_active;
    logic w_empty;
    logic w_full;
    logic w_mem_write;
    logic w_mem_done;
    logic w_accept;
    logic w_push;
    logic w_drop;
    logic w_begin;
    logic w_flush;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_active = (r_state == S_REC) || (r_state == S_DRAIN);

    // During an abort only the already-presented write is kept alive until it is taken.
    assign w_mem_write = (w_active && !w_empty) || (r_state == S_ABORT);
    assign w_mem_done  = w_mem_write && !i_mem_wait;

    assign w_accept = (r_state == S_REC) && i_start && i_smp_valid && !i_pause && !i_stop
                      && (r_acc_cnt < CHUNK_WORDS);
    assign w_push   = w_accept && (!w_full || w_mem_done);
    assign w_drop   = w_accept && w_full && !w_mem_done;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        w_next_state = r_state;
        w_begin      = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start && !r_start_q) begin
                    w_next_state = S_REC;
                    w_begin      = 1'b1;
                end
            end
            S_REC, S_DRAIN: begin
                if (!i_start) begin
                    if (w_mem_write && i_mem_wait) begin
                        w_next_state = S_ABORT;
                    end else begin
                        w_next_state = S_IDLE;
                        w_flush      = 1'b1;
                    end
                end else if (r_state == S_REC) begin
                    if (i_stop || (r_acc_cnt == CHUNK_WORDS)) begin
                        w_next_state = S_DRAIN;
                    end
                end else if (w_empty) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (!i_start) begin
                    w_next_state = S_IDLE;
                end
            end
            S_ABORT: begin
                if (!i_mem_wait) begin
                    w_next_state = S_IDLE;
                    w_flush      = 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_flush      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_start_q  <= 1'b0;
            r_base     <= '0;
            r_acc_cnt  <= '0;
            r_wr_cnt   <= '0;
            r_overflow <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state   <= w_next_state;
            r_start_q <= i_start;

            if (w_begin) begin
                r_base <= i_select;
            end

            if (w_begin) begin
                r_acc_cnt <= '0;
            end else if (w_push) begin
                r_acc_cnt <= r_acc_cnt + 23'd1;
            end

            if (w_begin) begin
                r_wr_cnt <= '0;
            end else if (w_mem_done) begin
                r_wr_cnt <= r_wr_cnt + 23'd1;
            end

            if (w_begin) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end

            if (w_begin || w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end
                if (w_mem_done) begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                end
            end
        end
    end

    // NOTE: the sample storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[AW-1:0]] <= i_smp_data;
        end
    end

    assign o_done      = (r_state == S_DONE);
    assign o_rec_len   = o_done ? r_wr_cnt : '0;
    assign o_overflow  = r_overflow;
    assign o_mem_write = w_mem_write;
    // Address and data are forced to zero when no write is requested (unwritten FIFO slots are X).
    assign o_mem_addr  = w_mem_write ? (r_base + r_wr_cnt) : '0;
    assign o_mem_wdata = w_mem_write ? r_fifo[r_rd_ptr[AW-1:0]] : '0;

endmodule

// File: tb/tb_record_engine.sv
// Bench for record_engine: a cycle table for the basic session plus directed sequences
// for chunk limit, overflow, stop/sample collision, pause, address wrap, abort and reset.
module tb_record_engine;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [22:0] i_select;
    logic        i_pause;
    logic        i_stop;
    logic        i_smp_valid;
    logic [15:0] i_smp_data;
    logic        i_mem_wait;

    logic        o_done,      o_done4;
    logic        o_mem_write, o_mem_write4;
    logic [22:0] o_mem_addr,  o_mem_addr4;
    logic [15:0] o_mem_wdata, o_mem_wdata4;
    logic [22:0] o_rec_len,   o_rec_len4;
    logic        o_overflow,  o_overflow4;

    int n_vec = 0;
    int n_bad = 0;

    logic [38:0] wr_q[$];
    logic [38:0] wr4_q[$];
    logic [38:0] exp_q[$];

    typedef struct {
        logic        start;
        logic [22:0] sel;
        logic        stop;
        logic        valid;
        logic [15:0] data;
        logic        done;
        logic        wr;
        logic [22:0] addr;
        logic [15:0] wdata;
        logic [22:0] len;
    } vec_t;

    vec_t tbl[$];

    always #5 i_clk = ~i_clk;

    record_engine dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_select(i_select),
        .i_pause(i_pause), .i_stop(i_stop), .o_done(o_done),
        .i_smp_valid(i_smp_valid), .i_smp_data(i_smp_data),
        .o_mem_write(o_mem_write), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_wait(i_mem_wait), .o_rec_len(o_rec_len), .o_overflow(o_overflow)
    );

    record_engine #(.CHUNK_WORDS(23'd4), .FIFO_DEPTH(16)) dut4 (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_select(i_select),
        .i_pause(i_pause), .i_stop(i_stop), .o_done(o_done4),
        .i_smp_valid(i_smp_valid), .i_smp_data(i_smp_data),
        .o_mem_write(o_mem_write4), .o_mem_addr(o_mem_addr4), .o_mem_wdata(o_mem_wdata4),
        .i_mem_wait(i_mem_wait), .o_rec_len(o_rec_len4), .o_overflow(o_overflow4)
    );

    // Completed writes: write requested and not stalled, captured mid-cycle.
    always @(negedge i_clk) begin
        if (!i_rst && o_mem_write && !i_mem_wait) wr_q.push_back({o_mem_addr, o_mem_wdata});
        if (!i_rst && o_mem_write4 && !i_mem_wait) wr4_q.push_back({o_mem_addr4, o_mem_wdata4});
    end

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        i_start     = 1'b0;
        i_pause     = 1'b0;
        i_stop      = 1'b0;
        i_smp_valid = 1'b0;
        i_smp_data  = '0;
        i_mem_wait  = 1'b0;
        repeat (n) step();
    endtask

    task automatic session(input logic [22:0] sel);
        i_start  = 1'b1;
        i_select = sel;
        step();
    endtask

    task automatic sample(input logic [15:0] d, input logic pause);
        i_smp_valid = 1'b1;
        i_smp_data  = d;
        i_pause     = pause;
        step();
        i_smp_valid = 1'b0;
        i_pause     = 1'b0;
    endtask

    task automatic expect_write(input logic [22:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic check_writes(input string name, input bit use4);
        logic [38:0] q[$];
        if (use4) q = wr4_q;
        else q = wr_q;
        check($sformatf("%s write count", name), 40'(q.size()), 40'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < q.size()) check($sformatf("%s write[%0d] addr/data", name, i), 40'(q[i]), 40'(exp_q[i]));
        end
    endtask

    task automatic clear_logs();
        wr_q.delete();
        wr4_q.delete();
        exp_q.delete();
    endtask

    // Raise stop (optionally with a colliding sample), wait for done, check length and writes.
    task automatic finish_session(input string name, input logic [22:0] exp_len,
                                  input bit with_smp, input logic [15:0] smp);
        int c;
        i_stop      = 1'b1;
        i_smp_valid = with_smp;
        i_smp_data  = smp;
        step();
        i_stop      = 1'b0;
        i_smp_valid = 1'b0;
        c = 0;
        while (!o_done && c < 200) begin
            step();
            c++;
        end
        check({name, " done"}, 40'(o_done), 40'd1);
        check({name, " rec_len"}, 40'(o_rec_len), 40'(exp_len));
        check_writes(name, 1'b0);
        i_start = 1'b0;
        step();
        check({name, " done after start low"}, 40'(o_done), 40'd0);
        idle(2);
    endtask

    function automatic vec_t mk(input logic st, input logic sp, input logic v, input logic [15:0] d,
                                input logic dn, input logic w, input logic [22:0] a,
                                input logic [15:0] wd, input logic [22:0] ln);
        vec_t t;
        t.start = st;  t.sel = 23'h040000; t.stop = sp;  t.valid = v;  t.data = d;
        t.done  = dn;  t.wr  = w;          t.addr = a;   t.wdata = wd; t.len  = ln;
        return t;
    endfunction

    initial begin
        int c;

        // Cycle table for the basic session: outputs expected during the cycle, then inputs.
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 23'h0, 16'h0, 23'd0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 23'h0, 16'h0, 23'd0));
        for (int k = 2; k <= 8; k++)
            tbl.push_back(mk(1'b1, 1'b0, 1'b1, 16'(k), 1'b0, 1'b1,
                             23'h040000 + 23'(k - 2), 16'(k - 1), 23'd0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 23'h040007, 16'h0008, 23'd0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 23'h0, 16'h0, 23'd0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 23'h0, 16'h0, 23'd8));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 23'h0, 16'h0, 23'd8));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 23'h0, 16'h0, 23'd0));

        // Reset state
        i_rst    = 1'b1;
        i_select = '0;
        idle(0);
        repeat (2) @(posedge i_clk);
        #1;
        check("reset done",     40'(o_done),      40'd0);
        check("reset write",    40'(o_mem_write), 40'd0);
        check("reset addr",     40'(o_mem_addr),  40'd0);
        check("reset wdata",    40'(o_mem_wdata), 40'd0);
        check("reset rec_len",  40'(o_rec_len),   40'd0);
        check("reset overflow", 40'(o_overflow),  40'd0);
        i_rst = 1'b0;
        idle(3);
        clear_logs();

        // 1: basic session from the table
        for (int i = 0; i < tbl.size(); i++) begin
            check($sformatf("t1[%0d] done", i),    40'(o_done),      40'(tbl[i].done));
            check($sformatf("t1[%0d] write", i),   40'(o_mem_write), 40'(tbl[i].wr));
            check($sformatf("t1[%0d] addr", i),    40'(o_mem_addr),  40'(tbl[i].addr));
            check($sformatf("t1[%0d] wdata", i),   40'(o_mem_wdata), 40'(tbl[i].wdata));
            check($sformatf("t1[%0d] rec_len", i), 40'(o_rec_len),   40'(tbl[i].len));
            i_start     = tbl[i].start;
            i_select    = tbl[i].sel;
            i_stop      = tbl[i].stop;
            i_smp_valid = tbl[i].valid;
            i_smp_data  = tbl[i].data;
            step();
        end
        for (int k = 0; k < 8; k++) expect_write(23'h040000 + 23'(k), 16'(k + 1));
        check_writes("t1", 1'b0);
        idle(3);
        clear_logs();

        // 2: chunk limit of 4 words, 6 samples offered, no stop
        session(23'h000200);
        for (int k = 0; k < 6; k++) sample(16'h2000 + 16'(k), 1'b0);
        c = 0;
        while (!o_done4 && c < 100) begin
            step();
            c++;
        end
        check("t2 done", 40'(o_done4), 40'd1);
        check("t2 rec_len", 40'(o_rec_len4), 40'd4);
        for (int k = 0; k < 4; k++) expect_write(23'h000200 + 23'(k), 16'h2000 + 16'(k));
        check_writes("t2", 1'b1);
        idle(3);
        clear_logs();

        // 3: memory stalled for 40 cycles with a sample every cycle -> overflow, stable port
        i_mem_wait = 1'b1;
        session(23'h001000);
        for (int k = 0; k < 40; k++) begin
            if (k >= 1) begin
                check($sformatf("t3 stall write c%0d", k), 40'(o_mem_write), 40'd1);
                check($sformatf("t3 stall addr c%0d", k),  40'(o_mem_addr),  40'h1000);
                check($sformatf("t3 stall data c%0d", k),  40'(o_mem_wdata), 40'h3000);
            end
            sample(16'h3000 + 16'(k), 1'b0);
        end
        check("t3 overflow", 40'(o_overflow), 40'd1);
        check("t3 no write during stall", 40'(wr_q.size()), 40'd0);
        i_mem_wait = 1'b0;
        for (int k = 0; k < 16; k++) expect_write(23'h001000 + 23'(k), 16'h3000 + 16'(k));
        finish_session("t3", 23'd16, 1'b0, 16'h0);
        clear_logs();

        // 4: stop and sample in the same cycle -> that sample is never written
        session(23'h002000);
        for (int k = 1; k <= 3; k++) sample(16'(k), 1'b0);
        for (int k = 0; k < 3; k++) expect_write(23'h002000 + 23'(k), 16'(k + 1));
        finish_session("t4", 23'd3, 1'b1, 16'h0BAD);
        clear_logs();

        // 5: pause during samples 3..5 of 8
        session(23'h003000);
        for (int k = 1; k <= 8; k++) sample(16'(k), (k >= 3 && k <= 5));
        expect_write(23'h003000, 16'd1);
        expect_write(23'h003001, 16'd2);
        expect_write(23'h003002, 16'd6);
        expect_write(23'h003003, 16'd7);
        expect_write(23'h003004, 16'd8);
        finish_session("t5", 23'd5, 1'b0, 16'h0);
        clear_logs();

        // 6: address wraps at the top of the 23-bit space
        session(23'h7FFFFE);
        for (int k = 0; k < 4; k++) sample(16'h6001 + 16'(k), 1'b0);
        expect_write(23'h7FFFFE, 16'h6001);
        expect_write(23'h7FFFFF, 16'h6002);
        expect_write(23'h000000, 16'h6003);
        expect_write(23'h000001, 16'h6004);
        finish_session("t6", 23'd4, 1'b0, 16'h0);
        clear_logs();

        // Abort: start dropped mid-REC while the memory stalls
        i_mem_wait = 1'b1;
        session(23'h000100);
        sample(16'h00A1, 1'b0);
        sample(16'h00A2, 1'b0);
        sample(16'h00A3, 1'b0);
        i_start = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("abort hold write c%0d", k), 40'(o_mem_write), 40'd1);
            check($sformatf("abort hold addr c%0d", k),  40'(o_mem_addr),  40'h100);
            check($sformatf("abort hold data c%0d", k),  40'(o_mem_wdata), 40'h00A1);
            check($sformatf("abort done c%0d", k),       40'(o_done),      40'd0);
            step();
        end
        i_mem_wait = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("abort idle write c%0d", k), 40'(o_mem_write), 40'd0);
            check($sformatf("abort idle done c%0d", k),  40'(o_done),      40'd0);
            step();
        end
        expect_write(23'h000100, 16'h00A1);
        check_writes("abort", 1'b0);
        clear_logs();

        // Session after abort starts from an empty FIFO at the new base
        session(23'h000400);
        sample(16'h0C01, 1'b0);
        expect_write(23'h000400, 16'h0C01);
        finish_session("post-abort", 23'd1, 1'b0, 16'h0);
        clear_logs();

        // Reset mid-operation drops the pending write immediately
        i_mem_wait = 1'b1;
        session(23'h000500);
        sample(16'h0D01, 1'b0);
        sample(16'h0D02, 1'b0);
        check("mid-reset write before", 40'(o_mem_write), 40'd1);
        i_rst = 1'b1;
        #1;
        check("mid-reset write", 40'(o_mem_write), 40'd0);
        check("mid-reset addr",  40'(o_mem_addr),  40'd0);
        check("mid-reset wdata", 40'(o_mem_wdata), 40'd0);
        check("mid-reset done",  40'(o_done),      40'd0);
        step();
        i_rst = 1'b0;
        idle(3);
        clear_logs();
        session(23'h000600);
        sample(16'h0E01, 1'b0);
        expect_write(23'h000600, 16'h0E01);
        finish_session("post-reset", 23'd1, 1'b0, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
